// File: rtl/return_change_timer_pkg.sv
// rtl/return_change_timer_pkg.sv - shared sizes, timer reload value and FSM state encoding
package return_change_timer_pkg;

  localparam int kNumCoins  = 3;
  localparam int kNumItems  = 4;
  localparam int kTotalBits = 31;

  localparam logic [31:0] kWaitTime = 32'd10;

  typedef enum logic {
    kStateCount  = 1'b0,
    kStateReturn = 1'b1
  } state_t;

  // Denominations are 32-bit, so the balance is zero-extended before comparing.
  function automatic logic [31:0] widen_total(input logic [kTotalBits-1:0] total);
    return {{(32-kTotalBits){1'b0}}, total};
  endfunction

endpackage

// File: rtl/coin_selector.sv
// rtl/coin_selector.sv - picks the largest denomination that fits the balance, or none
module coin_selector
  import return_change_timer_pkg::*;
(
  input  logic [kTotalBits-1:0]     i_total,
  input  logic [kNumCoins-1:0][31:0] i_coin_value,
  output logic [kNumCoins-1:0]      o_coin
);

  logic [31:0] w_total;

  assign w_total = widen_total(i_total);

  // Denominations ascend by index, so the last fitting index wins.
  always_comb begin
    o_coin = '0;
    for (int i = 0; i < kNumCoins; i++) begin
      if (i_coin_value[i] <= w_total) begin
        o_coin    = '0;
        o_coin[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/return_change_timer.sv
// rtl/return_change_timer.sv - inactivity timer and one-coin-per-cycle change return FSM
module return_change_timer
  import return_change_timer_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [kNumCoins-1:0]      i_input_coin,
  input  logic                      i_trigger_return,
  input  logic [kNumItems-1:0]      o_output_item,
  input  logic [kTotalBits-1:0]     current_total,
  input  logic [kNumCoins-1:0][31:0] coin_value,
  output logic [31:0]               wait_time,
  output logic [kNumCoins-1:0]      o_return_coin,
  output logic                      o_return_busy
);

  state_t      r_state;
  logic [31:0] r_wait_time;
  logic        r_busy;

  logic [kNumCoins-1:0] w_pick;
  logic                 w_activity;
  logic                 w_drained;

  coin_selector u_coin_selector (
    .i_total      (current_total),
    .i_coin_value (coin_value),
    .o_coin       (w_pick)
  );

  assign w_activity = (|i_input_coin) | (|o_output_item);
  assign w_drained  = ~(|w_pick);

  // Kept combinational so the coin always tracks the balance it is paid from.
  assign o_return_coin = (r_state == kStateReturn) ? w_pick : '0;
  assign o_return_busy = r_busy;
  assign wait_time     = reset ? 32'd0 : r_wait_time;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= kStateCount;
      r_wait_time <= kWaitTime;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        kStateCount: begin
          if (i_trigger_return) begin
            r_state     <= kStateReturn;
            r_wait_time <= 32'd1;
            r_busy      <= 1'b1;
          end else if (w_activity) begin
            r_wait_time <= kWaitTime;
          end else if (r_wait_time == 32'd1) begin
            r_state <= kStateReturn;
            r_busy  <= 1'b1;
          end else begin
            r_wait_time <= r_wait_time - 32'd1;
          end
        end
        kStateReturn: begin
          // Holding at 1 keeps the calculation stage applying return deductions.
          if (w_drained) begin
            r_state     <= kStateCount;
            r_wait_time <= kWaitTime;
            r_busy      <= 1'b0;
          end else begin
            r_wait_time <= 32'd1;
          end
        end
        default: begin
          r_state     <= kStateCount;
          r_wait_time <= kWaitTime;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_return_change_timer.sv
// tb/tb_return_change_timer.sv - directed and random checks against a balance/timer model
module tb_return_change_timer;
  import return_change_timer_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [kNumCoins-1:0]      i_input_coin;
  logic                      i_trigger_return;
  logic [kNumItems-1:0]      o_output_item;
  logic [kTotalBits-1:0]     current_total;
  logic [kNumCoins-1:0][31:0] coin_value;
  logic [31:0]               wait_time;
  logic [kNumCoins-1:0]      o_return_coin;
  logic                      o_return_busy;

  always #5 clk = ~clk;

  return_change_timer dut (
    .clk              (clk),
    .reset            (reset),
    .i_input_coin     (i_input_coin),
    .i_trigger_return (i_trigger_return),
    .o_output_item    (o_output_item),
    .current_total    (current_total),
    .coin_value       (coin_value),
    .wait_time        (wait_time),
    .o_return_coin    (o_return_coin),
    .o_return_busy    (o_return_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int denom [3] = '{100, 500, 1000};
  int m_total;
  bit m_ret;
  int m_wait;

  function automatic logic [2:0] greedy(input int total);
    logic [2:0] one;
    one = 3'b001;
    for (int i = 2; i >= 0; i--) begin
      if (total >= denom[i]) return one << i;
    end
    return 3'b000;
  endfunction

  function automatic int coin_val(input logic [2:0] c);
    int v;
    v = 0;
    for (int i = 0; i < 3; i++) if (c[i]) v += denom[i];
    return v;
  endfunction

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks = n_checks + 1;
    assert (got === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic cycle(input logic [2:0] coin, input logic trig, input logic [3:0] item);
    logic [2:0] exp_coin;
    i_input_coin     = coin;
    i_trigger_return = trig;
    o_output_item    = item;
    current_total    = kTotalBits'(m_total);
    #1;
    exp_coin = m_ret ? greedy(m_total) : 3'b000;
    chk("wait_time", wait_time, m_wait);
    chk("return_coin", o_return_coin, exp_coin);
    chk("return_busy", o_return_busy, m_ret);
    m_total = m_total + coin_val(coin) - coin_val(exp_coin);
    if (m_ret) begin
      if (exp_coin == 3'b000) begin
        m_ret  = 0;
        m_wait = 10;
      end else begin
        m_wait = 1;
      end
    end else if (trig) begin
      m_ret  = 1;
      m_wait = 1;
    end else if (coin != 0 || item != 0) begin
      m_wait = 10;
    end else if (m_wait == 1) begin
      m_ret = 1;
    end else begin
      m_wait = m_wait - 1;
    end
    @(posedge clk);
    #1;
    current_total = kTotalBits'(m_total);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(3'b000, 1'b0, 4'b0000);
  endtask

  initial begin
    logic [2:0] rc;
    logic [3:0] ri;
    logic       rt;
    coin_value       = {32'd1000, 32'd500, 32'd100};
    reset            = 1'b1;
    i_input_coin     = '0;
    i_trigger_return = 1'b0;
    o_output_item    = '0;
    m_total          = 1600;
    current_total    = kTotalBits'(m_total);
    m_ret            = 0;
    m_wait           = 10;

    // Reset held: timer reads zero, nothing returned even with a balance present.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_wait", wait_time, 0);
    chk("reset_coin", o_return_coin, 0);
    chk("reset_busy", o_return_busy, 0);
    @(negedge clk);
    reset   = 1'b0;
    m_total = 0;

    // Timeout return of a single 500 coin.
    cycle(3'b010, 1'b0, 4'b0000);
    idle(13);

    // Triggered multi-coin drain of 1600.
    m_total = 1600;
    cycle(3'b000, 1'b1, 4'b0000);
    idle(5);

    // Reload on coin at wait_time 3 and on item at wait_time 5.
    while (m_wait != 3) cycle(3'b000, 1'b0, 4'b0000);
    cycle(3'b001, 1'b0, 4'b0000);
    while (m_wait != 5) cycle(3'b000, 1'b0, 4'b0000);
    cycle(3'b000, 1'b0, 4'b0010);
    idle(2);

    // Trigger together with a coin at balance 500.
    m_total = 500;
    cycle(3'b001, 1'b1, 4'b0000);
    idle(4);

    // Sub-coin remainder at timeout.
    m_total = 50;
    idle(14);

    // Reset during a drain: outputs drop at once, balance is kept.
    m_total = 1600;
    cycle(3'b000, 1'b1, 4'b0000);
    cycle(3'b000, 1'b0, 4'b0000);
    reset = 1'b1;
    #1;
    chk("midreset_wait", wait_time, 0);
    chk("midreset_coin", o_return_coin, 0);
    chk("midreset_busy", o_return_busy, 0);
    @(negedge clk);
    reset  = 1'b0;
    m_ret  = 0;
    m_wait = 10;
    idle(3);

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      rc = ($urandom_range(0, 15) == 0) ? (3'(1) << $urandom_range(0, 2)) : 3'b000;
      rt = ($urandom_range(0, 39) == 0);
      ri = ($urandom_range(0, 19) == 0) ? (4'(1) << $urandom_range(0, 3)) : 4'b0000;
      cycle(rc, rt, ri);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/return_change_timer.md
# return_change_timer

Inactivity timer and change-return sequencer for the vending machine. It sits beside the total/availability calculation stage. It produces `wait_time` and `o_return_coin`, which that stage consumes when it computes the next `current_total`, and it consumes the registered `current_total` and `o_output_item` that the stage produces. On timeout or an explicit return request it drains the balance one coin per cycle, largest denomination first.

## Interface
Parameters and defines (from `vending_machine_def.v`):
- `kNumCoins`, 3: number of coin denominations.
- `kNumItems`, 4: number of items.
- `kTotalBits`, 31: width of `current_total`.
- `kWaitTime`, 10: timer reload value, in cycles.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `i_input_coin` input kNumCoins: one-hot coin inserted this cycle.
- `i_trigger_return` input 1: user request to return the balance.
- `o_output_item` input kNumItems: items dispensed this cycle, from the calculation stage.
- `current_total` input kTotalBits: registered balance.
- `coin_value` input 32 x kNumCoins: denominations, strictly ascending by index.
- `wait_time` output 32: remaining inactivity time. It is nonzero except during reset.
- `o_return_coin` output kNumCoins: one-hot coin returned this cycle. It is combinational.
- `o_return_busy` output 1: high while in RETURN; the top level masks `i_select_item` with it.

## Operation
States: COUNT and RETURN.

Reset values:
- state = COUNT.
- `wait_time` = kWaitTime.
- `o_return_coin` = 0.
- `o_return_busy` = 0.
- `wait_time` reads 0 only while `reset` is high.

COUNT, evaluated at each edge in priority order:
1. `i_trigger_return` = 1: go to RETURN; `wait_time` becomes 1.
2. Any bit of `i_input_coin` or `o_output_item` set: `wait_time` reloads to kWaitTime.
3. `wait_time` = 1: go to RETURN; `wait_time` holds at 1.
4. Otherwise: `wait_time` decrements by 1.

RETURN:
- `wait_time` is held at 1, so the calculation stage keeps accepting return deductions.
- `o_return_coin` is the one-hot of the highest index i with `coin_value[i]` <= `current_total`. Comparison is unsigned, with `current_total` zero-extended to 32 bits.
- If `current_total` < `coin_value[0]`, `o_return_coin` = 0. At that edge the block goes to COUNT and `wait_time` reloads to kWaitTime.
- `i_input_coin`, `i_trigger_return` and `o_output_item` are ignored by the FSM. Coins inserted during RETURN are added upstream and drained in the same sequence.

`o_return_coin` is a function of state and `current_total` only. It must not be registered; registering it would return a stale coin after the balance has dropped.

`o_return_busy` = (state == RETURN), driven from the state register.

## Timing
- The coin is returned in the same cycle as the balance it is computed from. `current_total` drops by that coin's value at the next edge.
- A balance needing N coins takes N cycles of coins plus 1 empty exit cycle, so `o_return_busy` is high for N+1 cycles.
- From the last activity to the first returned coin: kWaitTime-1 cycles of countdown, then RETURN is entered on the edge where `wait_time` = 1.
- From `i_trigger_return` sampled to the first coin: 1 cycle.
- Asserting `reset` mid-RETURN returns all outputs to their reset values immediately. The balance is not returned.

## Structure
- `vending_machine_def.v` holds kNumCoins, kNumItems, kTotalBits, kWaitTime and the state encodings `kStateCount`/`kStateReturn`.
- One sub-module, `coin_selector`: a combinational priority picker that maps `current_total` and `coin_value` to the largest fitting one-hot coin, or 0.
- The FSM and timer registers stay in `return_change_timer`.

## Test plan
All scenarios use coin values 100/500/1000 and kWaitTime 10.
- **Reset:** assert `reset` -> `wait_time` = 0 while held; after release `wait_time` = 10, `o_return_coin` = 0, `o_return_busy` = 0.
- **Timeout return:** insert 500, then stay idle -> `wait_time` counts 10, 9, ..., 1. Enter RETURN -> `o_return_coin` = 3'b010 for one cycle, then 0. Back in COUNT with `wait_time` = 10.
- **Trigger with multi-coin balance:** balance 1600, pulse `i_trigger_return` -> coins 3'b100, 3'b010, 3'b001 on consecutive cycles. `o_return_busy` is high for 4 cycles; final balance 0.
- **Reload on activity:** insert a coin when `wait_time` = 3 -> next `wait_time` = 10. Dispense an item when `wait_time` = 5 -> next `wait_time` = 10.
- **Simultaneous events:** `i_trigger_return` together with a 100 coin at balance 500 -> RETURN entered. Coins 500 then 100 are returned; balance 0.
- **Sub-coin remainder and reset mid-RETURN:** balance 50 at timeout -> one RETURN cycle with no coin, then COUNT. Separately, assert `reset` during a drain -> outputs go to reset values immediately.
